// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pkg
//  Purpose  : Shared types and helpers for the radix-4 Booth multiplier slice
//  Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } booth_ctrl_state_t;

   // Radix-4 digit count: unsigned operands need one extra digit to absorb
   // the zero-extended MSB.
   function automatic int booth_iters(input int width, input logic is_signed);
      return is_signed ? (width / 2) : (width / 2 + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module   : booth_iter_counter
//  Purpose  : Step counter for the Booth sequencer with synchronous clear and
//             a terminal-count flag compared against a runtime limit
//  Revision : 1.0 - initial release
// ============================================================================
module booth_iter_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_count;

   // Clear dominates increment so the sequencer can restart from zero at will
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + c_ONE;
      end
   end

   assign count = r_count;
   assign last  = (r_count == limit);

endmodule
`default_nettype wire

// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : booth_seq_ctrl
//  Purpose  : Sequencing FSM for the iterative radix-4 Booth multiplier.
//             Accepts operands, pulses load, issues one step strobe per
//             radix-4 digit and holds the result handshake until taken.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter  int WIDTH  = 16,
   localparam int ITER_U = WIDTH / 2 + 1,
   localparam int CNT_W  = $clog2(ITER_U + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_signed,
   output logic             in_ready,
   input  logic             abort,
   output logic             load,
   output logic             step_en,
   output logic             signed_q,
   output logic [CNT_W-1:0] iter,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int ITER_S = WIDTH / 2;
   localparam logic [CNT_W-1:0] c_LIM_S = CNT_W'(booth_iters(WIDTH, 1'b1) - 1);
   localparam logic [CNT_W-1:0] c_LIM_U = CNT_W'(booth_iters(WIDTH, 1'b0) - 1);

   booth_ctrl_state_t r_state;
   logic              r_signed_q;
   logic              r_load;
   logic              r_step_en;
   logic              r_busy;
   logic              r_out_valid;
   logic              r_in_ready;

   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_limit;
   logic              w_last;
   logic              w_clr;
   logic              w_en;

   // The counter only advances in RUN; any other state, an abort or the final
   // step returns it to zero so iter reads 0 whenever step_en is low.
   assign w_en    = (r_state == RUN);
   assign w_clr   = (r_state != RUN) || abort || w_last;
   assign w_limit = r_signed_q ? c_LIM_S : c_LIM_U;

   booth_iter_counter #(
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .en    (w_en),
      .limit (w_limit),
      .count (w_count),
      .last  (w_last)
   );

   // State transitions and registered strobes; in_ready comes back one cycle
   // after re-entering IDLE, so no accept can happen on the way out of DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_signed_q  <= 1'b0;
         r_load      <= 1'b0;
         r_step_en   <= 1'b0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_load      <= 1'b0;
         r_step_en   <= 1'b0;
         r_out_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_in_ready && in_valid) begin
                  r_state    <= LOAD;
                  r_signed_q <= in_signed;
                  r_in_ready <= 1'b0;
                  r_load     <= 1'b1;
                  r_busy     <= 1'b1;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state   <= RUN;
                  r_step_en <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_last) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_step_en <= 1'b1;
               end
            end
            DONE: begin
               if (abort || out_ready) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign load      = r_load;
   assign step_en   = r_step_en;
   assign signed_q  = r_signed_q;
   assign iter      = w_count;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_seq_ctrl
//  Purpose  : Scoreboard testbench for booth_seq_ctrl (WIDTH=16)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_ctrl;

   localparam int WIDTH = 16;
   localparam int CNT_W = $clog2(WIDTH / 2 + 2);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_signed;
   logic             in_ready;
   logic             abort;
   logic             load;
   logic             step_en;
   logic             signed_q;
   logic [CNT_W-1:0] iter;
   logic             busy;
   logic             out_valid;
   logic             out_ready;

   booth_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_signed (in_signed),
      .in_ready  (in_ready),
      .abort     (abort),
      .load      (load),
      .step_en   (step_en),
      .signed_q  (signed_q),
      .iter      (iter),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic s;
      int   t_acc;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   or_mode = 1;   // 0 random, 1 always ready, 2 never ready

   // Reference: one radix-4 digit per two bits, plus one for unsigned operands
   function automatic int ref_iters(input logic s);
      return s ? (WIDTH / 2) : (WIDTH / 2 + 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic s);
      int n = 0;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         return;
      end
      in_valid  = 1'b1;
      in_signed = s;
      sb.push_back('{s, cyc + 1});
      tick();
      in_valid  = 1'b0;
      in_signed = 1'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy || !in_ready) && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   // out_ready driver, applied slightly after the stimulus phase
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (or_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: observes the DUT mid-cycle and checks it against the scoreboard
   int   steps  = 0;
   logic prev_ov = 1'b0;
   logic prev_or = 1'b0;
   int   hs_age = 0;
   logic ab_pend = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_strobes", 32'({load, step_en, out_valid}), 32'd0);
         chk("rst_iter", 32'(iter), 32'd0);
         chk("rst_signed_q", 32'(signed_q), 32'd0);
         steps   = 0;
         prev_ov = 1'b0;
         prev_or = 1'b0;
         hs_age  = 0;
         ab_pend = 1'b0;
      end else if (ab_pend) begin
         chk("abort_busy", 32'(busy), 32'd0);
         chk("abort_strobes", 32'({load, step_en, out_valid}), 32'd0);
         ab_pend = 1'b0;
         steps   = 0;
         prev_ov = out_valid;
         prev_or = out_ready;
      end else begin
         chk("load_step_excl", 32'(load & step_en), 32'd0);
         chk("ov_step_excl", 32'(out_valid & step_en), 32'd0);
         if (load) begin
            if (sb.size() == 0) chk("load_unexpected", 32'd1, 32'd0);
            else chk("load_latency", 32'(cyc), 32'(sb[0].t_acc));
         end
         if (step_en) begin
            chk("iter_index", 32'(iter), 32'(steps));
            if (sb.size() != 0) chk("signed_q_run", 32'(signed_q), 32'(sb[0].s));
            steps++;
         end
         if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
               chk("result_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_latency", 32'(cyc), 32'(e.t_acc + 1 + ref_iters(e.s)));
               chk("step_count", 32'(steps), 32'(ref_iters(e.s)));
               chk("signed_q_done", 32'(signed_q), 32'(e.s));
            end
            steps = 0;
         end
         if (prev_ov && !prev_or) begin
            chk("ov_held", 32'(out_valid), 32'd1);
            chk("ready_low_in_done", 32'(in_ready), 32'd0);
         end
         if (hs_age == 1) begin
            chk("post_hs_idle", 32'({busy, out_valid, in_ready}), 32'd0);
            hs_age = 2;
         end else if (hs_age == 2) begin
            chk("post_hs_ready", 32'(in_ready), 32'd1);
            hs_age = 0;
         end
         if (out_valid && out_ready && !abort) hs_age = 1;
         if (abort && busy) begin
            ab_pend = 1'b1;
            if (sb.size() != 0) void'(sb.pop_front());
         end
         prev_ov = out_valid;
         prev_or = out_ready;
      end
   end

   // Stimulus
   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_signed = 1'b0;
      abort     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_in_ready", 32'(in_ready), 32'd1);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_strobes", 32'({load, step_en, out_valid}), 32'd0);
      end

      // Signed then unsigned operation, in_signed toggling during the run
      issue(1'b1);
      wait_idle();
      issue(1'b0);
      for (int i = 0; i < 12; i++) begin
         in_signed = ~in_signed;
         in_valid  = 1'($urandom);
         tick();
      end
      in_valid = 1'b0;
      wait_idle();

      // Backpressure: result held for 5 cycles, in_valid ignored meanwhile
      or_mode = 2;
      issue(1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_held", 32'({out_valid, busy, in_ready}), 32'b110);
      end
      in_valid = 1'b0;
      or_mode  = 1;
      tick();
      tick();
      chk("bp_released", 32'({busy, out_valid}), 32'd0);
      wait_idle();

      // Abort at iter 3 together with in_valid
      issue(1'b1);
      n = 0;
      while (!(step_en && iter == 3) && n < 50) begin
         tick();
         n++;
      end
      chk("abort_point", 32'({step_en, 28'd0, iter}), {1'b1, 28'd0, 4'd3} );
      abort     = 1'b1;
      in_valid  = 1'b1;
      in_signed = 1'b0;
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_no_accept", 32'({busy, load, in_ready}), 32'd0);
      wait_idle();
      issue(1'b1);
      wait_idle();

      // Asynchronous reset mid-run at iter 5
      issue(1'b1);
      n = 0;
      @(negedge clk);
      while (!(step_en && iter == 5) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("areset_point", 32'(iter), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("areset_busy", 32'(busy), 32'd0);
      chk("areset_step_en", 32'(step_en), 32'd0);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      issue(1'b0);
      wait_idle();

      // Randomized traffic with random backpressure
      or_mode = 0;
      for (int i = 0; i < 40; i++) begin
         issue(1'($urandom));
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
      end
      wait_idle();
      or_mode = 1;
      repeat (3) tick();
      chk("final_queue_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
